// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master issues start with operands; the slave answers with busy/done and the result.
interface serial_subtractor_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         bi;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         bo;
    logic         zero;

    modport master (
        output start, x, y, bi,
        input  busy, done, d, bo, zero
    );

    modport slave (
        input  start, x, y, bi,
        output busy, done, d, bo, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: d = x - y - bi, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop replace the N-cell ripple chain.
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  xs_q, xs_d;
    logic [N-1:0]  ys_q, ys_d;
    logic [N-1:0]  ds_q, ds_d;
    logic          b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  d_q, d_d;
    logic          bo_q, bo_d;
    logic          zero_q, zero_d;

    // Full-subtractor cell outputs for the current bit position.
    logic          xi, yi, diff, b_next;

    // Next-state logic: handshake sequencing plus one bit of subtraction per RUN cycle.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves it unassigned (no latch).
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        ds_d    = ds_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        d_d     = d_q;
        bo_d    = bo_q;
        zero_d  = zero_q;

        xi      = xs_q[0];
        yi      = ys_q[0];
        diff    = xi ^ yi ^ b_q;
        b_next  = (~xi & yi) | (~(xi ^ yi) & b_q);

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    xs_d    = bus.x;
                    ys_d    = bus.y;
                    b_d     = bus.bi;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                ds_d  = {diff, ds_q[N-1:1]};
                b_d   = b_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Publish only the complete word; partial sums never reach d.
                    d_d     = ds_d;
                    bo_d    = b_next;
                    zero_d  = (ds_d == '0);
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (rst) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            ds_q    <= '0;
            b_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            ds_q    <= ds_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a timeline/arithmetic model checked every
// cycle, directed cases with literal results, then randomized traffic with resets.
module tb_serial_subtractor;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_if #(.N(N)) bus ();

    serial_subtractor #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start at edge t0 yields busy after edges t0..t0+N,
    // done after edge t0+N, and the next start is accepted at edge t0+N+2 or later.
    int           k       = 0;
    int           t0      = 0;
    bit           have_op = 1'b0;
    bit           seen_rst = 1'b0;
    logic [N-1:0] m_d = '0, p_d = '0;
    logic         m_bo = 1'b0, p_bo = 1'b0, m_zero = 1'b0;
    logic         m_busy = 1'b0, m_done = 1'b0;

    always @(posedge clk) begin
        logic [N:0] full;
        k++;
        if (rst) begin
            have_op  = 1'b0;
            seen_rst = 1'b1;
            m_d      = '0;
            m_bo     = 1'b0;
            m_zero   = 1'b0;
        end else begin
            if (bus.start && (!have_op || k >= t0 + N + 2)) begin
                t0      = k;
                have_op = 1'b1;
                full    = {1'b0, bus.x} - {1'b0, bus.y} - (N+1)'(bus.bi);
                p_d     = full[N-1:0];
                p_bo    = full[N];
            end
            if (have_op && k == t0 + N) begin
                m_d    = p_d;
                m_bo   = p_bo;
                m_zero = (p_d == '0);
            end
        end
        m_busy = have_op && k >= t0 && k <= t0 + N;
        m_done = have_op && k == t0 + N;
        #1;
        if (seen_rst) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
            check("d",    32'(bus.d),    32'(m_d));
            check("bo",   32'(bus.bo),   32'(m_bo));
            check("zero", 32'(bus.zero), 32'(m_zero));
        end
    end

    task automatic pulse(input logic [N-1:0] xv, input logic [N-1:0] yv, input logic bv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = xv;
        bus.y     = yv;
        bus.bi    = bv;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < N + 4 && !ok; i++) begin
            @(negedge clk);
            if (bus.done) ok = 1'b1;
        end
        check("done_within_bound", 32'(ok), 32'd1);
    endtask

    task automatic op_lit(input string name, input logic [N-1:0] xv, input logic [N-1:0] yv,
                          input logic bv, input logic [N-1:0] ed, input logic ebo, input logic ez);
        bit ok;
        pulse(xv, yv, bv);
        wait_done(ok);
        if (ok) begin
            check({name, "_d"},    32'(bus.d),    32'(ed));
            check({name, "_bo"},   32'(bus.bo),   32'(ebo));
            check({name, "_zero"}, 32'(bus.zero), 32'(ez));
        end
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        int busy_cycles, done_cycles, done_at, n_done, last_done;

        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        bus.bi    = 1'b0;

        // Reset for two cycles, then idle for five.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_d",    32'(bus.d),    32'd0);
        check("rst_bo",   32'(bus.bo),   32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        repeat (5) @(negedge clk);
        check("idle_d",    32'(bus.d),    32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Basic op: latency and busy length.
        @(negedge clk);
        bus.start = 1'b1; bus.x = 4'b0101; bus.y = 4'b0011; bus.bi = 1'b0;
        busy_cycles = 0; done_cycles = 0; done_at = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                done_cycles++;
                done_at = i;
                check("basic_d",    32'(bus.d),    32'b0010);
                check("basic_bo",   32'(bus.bo),   32'd0);
                check("basic_zero", 32'(bus.zero), 32'd0);
            end
        end
        check("basic_busy_cycles", 32'(busy_cycles), 32'd5);
        check("basic_done_cycles", 32'(done_cycles), 32'd1);
        check("basic_done_edge",   32'(done_at),     32'd4);

        // Borrow and wrap cases.
        op_lit("neg",  4'b0011, 4'b0101, 1'b1 ^ 1'b1, 4'b1110, 1'b1, 1'b0);
        op_lit("bi",   4'b0000, 4'b0000, 1'b1,        4'b1111, 1'b1, 1'b0);
        op_lit("eq",   4'b1111, 4'b1111, 1'b0,        4'b0000, 1'b0, 1'b1);

        // Second start while busy is ignored; result holds afterwards.
        @(negedge clk);
        bus.start = 1'b1; bus.x = 4'b1000; bus.y = 4'b0001; bus.bi = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.x = 4'b0000; bus.y = 4'b0001; bus.bi = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.x = 4'b1111; bus.y = 4'b1010;
        wait_done(ok);
        if (ok) begin
            check("ign_d",  32'(bus.d),  32'b0111);
            check("ign_bo", 32'(bus.bo), 32'd0);
        end
        repeat (6) @(negedge clk);
        check("hold_d", 32'(bus.d), 32'b0111);

        // Reset on the second RUN edge aborts the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.x = 4'b1001; bus.y = 4'b0010; bus.bi = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_d",    32'(bus.d),    32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        n_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        op_lit("after", 4'b0110, 4'b0110, 1'b1, 4'b1111, 1'b1, 1'b0);

        // start held high: one operation every N+2 edges.
        @(negedge clk);
        bus.start = 1'b1; bus.x = 4'b0100; bus.y = 4'b0001; bus.bi = 1'b0;
        n_done = 0; last_done = -1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (last_done >= 0) check("held_spacing", 32'(i - last_done), 32'(N + 2));
                else check("held_first", 32'(i), 32'(N));
                last_done = i;
                n_done++;
                check("held_d",  32'(bus.d),  32'b0011);
                check("held_bo", 32'(bus.bo), 32'd0);
            end
        end
        bus.start = 1'b0;
        check("held_count", 32'(n_done), 32'd3);
        repeat (N + 3) @(negedge clk);

        // Randomized traffic with spurious starts and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 149) == 0);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.x     = N'($urandom);
            bus.y     = N'($urandom);
            bus.bi    = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (N + 4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
